seq_multiplier: RTL
===================

# seq_multiplier

Parametrised, iterative shift-and-add multiplier with valid/ready handshakes on input and output. It generalises the fixed 3-bit times-table multiplier to any operand width and adds signed (two's complement) operation selected per transaction. It sits between an operand source (counter, switches or FIFO) and a result consumer, and can be chained directly to ready/valid peers.

## Interface
- WIDTH, 8, operand width in bits (≥2); result is 2*WIDTH bits.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b, mode are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- mode  input  1  0 = unsigned, 1 = signed two's complement.
- out_valid  output  1  result is valid and held.
- out_ready  input  1  consumer accepts result.
- result  output  2*WIDTH  product. Unsigned zero-extended; signed sign-correct two's complement.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1 (forced 0 while rst=1). On an edge with in_valid&in_ready: capture mode; capture |a| and |b| (magnitudes if mode=1, raw if mode=0); capture sign = mode & (a[MSB]^b[MSB]); clear accumulator; bit counter=0; go to CALC.
- CALC: one multiplier bit per cycle, LSB first. If the current bit=1, add the shifted multiplicand to a 2*WIDTH accumulator. Increment the counter.
- On the edge where the counter reaches WIDTH-1: result <= sign ? -(final sum) : final sum, computed in 2*WIDTH bits. Go to DONE.
- DONE: out_valid=1. result stays stable until the handshake completes. On an edge with out_ready=1: go to IDLE. result keeps its last value, and out_valid drops.
- in_ready=0 in CALC and DONE. in_valid is ignored there, and the operand inputs need not stay stable after acceptance.
- Arithmetic: the magnitude of the most-negative value (e.g. -4 for WIDTH=3) is represented in WIDTH unsigned bits with no overflow. The 2*WIDTH result never overflows in either mode.
- Reset (any state, including mid-CALC): next state IDLE, out_valid=0, result=0, accumulator/counter/sign cleared. An in-flight operation is discarded and no result is produced.
- in_valid held high across DONE→IDLE: accepted on the first IDLE edge. There is no acceptance in the same cycle as the output handshake.

## Timing
- Reset values: out_valid=0, result=0, in_ready=0 while rst=1; in_ready=1 the cycle after rst deasserts.
- Latency: accept at edge E0 → out_valid=1 after edge E0+WIDTH, i.e. CALC lasts exactly WIDTH cycles.
- Throughput with out_ready held high: one result per WIDTH+2 cycles (accept, WIDTH calc, DONE, IDLE).
- in_ready and out_valid are functions of registered state only. There is no combinational path from in_valid or out_ready.
- result changes only on the CALC→DONE edge or on reset.

## Test plan
- Reset: hold rst 2 cycles mid-stream → out_valid=0, result=0, in_ready=0 during reset and 1 the following cycle.
- WIDTH=3 unsigned times table: a=3, b=0..7 in sequence, out_ready=1 → results 0,3,6,…,21. Each out_valid rises exactly 3 cycles after its accept edge, and no result is missing or duplicated.
- WIDTH=3 signed: (a=3'b100, b=3'b100) → 6'd16; (a=3'b100, b=3'd3) → 6'b110100 (-12); (a=3'b111, b=3'd1) → 6'b111111. Same operands with mode=0 → 16, 12, 7.
- Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands applied → out_valid and result held, in_ready=0, no acceptance. out_ready=1 → IDLE next cycle, new operands accepted the cycle after.
- Reset mid-CALC: assert rst on the 2nd CALC cycle for 1 cycle → IDLE next cycle, out_valid never rises for that operation. The next transaction (a=5, b=6) → 30.
- WIDTH=8: 255×255 unsigned → 65025; signed -128×-128 → 16384; signed -128×127 → -16256 (16'hC080). Latency 8 cycles each.

Source files
------------

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier, unsigned or signed per transaction; one operand bit per cycle.
// Result appears WIDTH cycles after acceptance. It is held with out_valid until out_ready, and no new operands are taken meanwhile.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [2*WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]    mplier;
  logic [2*WIDTH-1:0]  acc;
  logic [CW-1:0]       cnt;
  logic                sign;

  logic                accept;
  logic                last_bit;
  logic [WIDTH-1:0]    mag_a, mag_b;
  logic [2*WIDTH-1:0]  sum;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = CALC;
      end
      CALC: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_valid && in_ready;
  assign last_bit = (cnt == CW'(WIDTH - 1));

  // The most-negative value negates to itself, which read unsigned is its correct magnitude.
  always_comb begin
    mag_a = (mode && a[WIDTH-1]) ? -a : a;
    mag_b = (mode && b[WIDTH-1]) ? -b : b;
    sum   = acc + (mplier[0] ? mcand : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      sign   <= 1'b0;
      result <= '0;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= '0;
      sign   <= mode && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (state == CALC) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_bit) result <= sign ? -sum : sum;
    end
  end

endmodule
